// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: FSM state encoding, key geometry and memory timing.
// Used by both the encrypt and the decrypt/crack datapaths.
package arc4_pkg;

    localparam int KEY_BYTES = 3;
    localparam int KEY_W     = 8 * KEY_BYTES;
    localparam int MEM_LAT   = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_RI,
        ST_KSA_RJ,
        ST_KSA_WI,
        ST_KSA_WJ,
        ST_LEN_RD,
        ST_PRGA_RI,
        ST_PRGA_RJ,
        ST_PRGA_SW,
        ST_PRGA_RK,
        ST_PRGA_WC,
        ST_DONE
    } arc4_enc_state_t;

    // Byte idx of a big-endian key: idx 0 is the most significant byte.
    function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] key, input logic [1:0] idx);
        logic [KEY_W-1:0] sh;
        sh = key << {idx, 3'b000};
        return sh[KEY_W-1 -: 8];
    endfunction

endpackage

// File: rtl/s_mem.sv
// 256x8 single-port state memory, synchronous write and one-cycle registered read.
// Read returns the old contents on a same-address write; no reset on the array.
module s_mem (
    input  logic       clk,
    input  logic [7:0] addr_i,
    input  logic [7:0] wrdata_i,
    input  logic       wren_i,
    output logic [7:0] rddata_o
);

    logic [7:0] mem_q [256];

    always_ff @(posedge clk) begin
        if (wren_i) begin
            mem_q[addr_i] <= wrdata_i;
        end
        rddata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: pt memory -> init/KSA/PRGA over internal S -> length-prefixed ct memory.
// en accepted only while rdy=1; runs to completion (1795 + 9*len busy cycles), no backpressure.
import arc4_pkg::*;

module arc4_encrypt (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key,
    output logic [7:0]       pt_addr,
    input  logic [7:0]       pt_rddata,
    output logic [7:0]       ct_addr,
    output logic [7:0]       ct_wrdata,
    output logic             ct_wren
);

    // Phase on which read data is valid, and the ct write phase of LEN_RD.
    localparam logic [1:0] PH_CAP = 2'(MEM_LAT);
    localparam logic [1:0] PH_WR  = PH_CAP + 2'd1;

    arc4_enc_state_t  state_q;
    logic [1:0]       ph_q;
    logic [7:0]       i_q, j_q, k_q, len_q, si_q, sj_q;
    logic [1:0]       kidx_q;
    logic [KEY_W-1:0] key_q;
    logic             rdy_q, ct_wren_q;
    logic [7:0]       pt_addr_q, ct_addr_q, ct_wrdata_q;

    logic [7:0] s_addr_d, s_wrdata_d, s_rddata;
    logic       s_wren_d;
    logic [7:0] j_ksa_d, j_prga_d, i_inc_d, pad_addr_d;

    assign j_ksa_d    = j_q + si_q + key_byte(key_q, kidx_q);
    assign j_prga_d   = j_q + si_q;
    assign i_inc_d    = i_q + 8'd1;
    assign pad_addr_d = si_q + sj_q;

    assign rdy       = rdy_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;

    // Address is taken from the next-value on phase 0 so it stays stable while the read is in flight.
    always_comb begin
        s_addr_d   = i_q;
        s_wrdata_d = 8'd0;
        s_wren_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                s_wrdata_d = i_q;
                s_wren_d   = 1'b1;
            end
            ST_KSA_RJ:  s_addr_d = (ph_q == 2'd0) ? j_ksa_d : j_q;
            ST_KSA_WI: begin
                s_wrdata_d = sj_q;
                s_wren_d   = 1'b1;
            end
            ST_KSA_WJ: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
            end
            ST_PRGA_RI: s_addr_d = (ph_q == 2'd0) ? i_inc_d : i_q;
            ST_PRGA_RJ: s_addr_d = (ph_q == 2'd0) ? j_prga_d : j_q;
            ST_PRGA_SW: begin
                s_addr_d   = (ph_q == 2'd0) ? i_q : j_q;
                s_wrdata_d = (ph_q == 2'd0) ? sj_q : si_q;
                s_wren_d   = 1'b1;
            end
            ST_PRGA_RK: s_addr_d = pad_addr_d;
            default: ;
        endcase
    end

    s_mem u_s_mem (
        .clk      (clk),
        .addr_i   (s_addr_d),
        .wrdata_i (s_wrdata_d),
        .wren_i   (s_wren_d),
        .rddata_o (s_rddata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ph_q        <= 2'd0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            kidx_q      <= 2'd0;
            key_q       <= '0;
            rdy_q       <= 1'b1;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (en) begin
                        key_q   <= key;
                        rdy_q   <= 1'b0;
                        i_q     <= 8'd0;
                        j_q     <= 8'd0;
                        kidx_q  <= 2'd0;
                        ph_q    <= 2'd0;
                        state_q <= ST_INIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_INIT: begin
                    i_q <= i_inc_d;
                    if (i_q == 8'hFF) begin
                        state_q <= ST_KSA_RI;
                    end
                end
                ST_KSA_RI: begin
                    if (ph_q == PH_CAP) begin
                        si_q    <= s_rddata;
                        ph_q    <= 2'd0;
                        state_q <= ST_KSA_RJ;
                    end else begin
                        ph_q <= ph_q + 2'd1;
                    end
                end
                ST_KSA_RJ: begin
                    if (ph_q == 2'd0) begin
                        j_q <= j_ksa_d;
                    end
                    if (ph_q == PH_CAP) begin
                        sj_q    <= s_rddata;
                        ph_q    <= 2'd0;
                        state_q <= ST_KSA_WI;
                    end else begin
                        ph_q <= ph_q + 2'd1;
                    end
                end
                ST_KSA_WI: state_q <= ST_KSA_WJ;
                ST_KSA_WJ: begin
                    kidx_q <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                    if (i_q == 8'hFF) begin
                        i_q       <= 8'd0;
                        j_q       <= 8'd0;
                        pt_addr_q <= 8'd0;
                        state_q   <= ST_LEN_RD;
                    end else begin
                        i_q     <= i_inc_d;
                        state_q <= ST_KSA_RI;
                    end
                end
                ST_LEN_RD: begin
                    if (ph_q == PH_CAP) begin
                        len_q       <= pt_rddata;
                        ct_addr_q   <= 8'd0;
                        ct_wrdata_q <= pt_rddata;
                        ct_wren_q   <= 1'b1;
                        ph_q        <= ph_q + 2'd1;
                    end else if (ph_q == PH_WR) begin
                        ct_wren_q <= 1'b0;
                        ph_q      <= 2'd0;
                        k_q       <= 8'd1;
                        if (len_q == 8'd0) begin
                            rdy_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_PRGA_RI;
                        end
                    end else begin
                        ph_q <= ph_q + 2'd1;
                    end
                end
                ST_PRGA_RI: begin
                    if (ph_q == 2'd0) begin
                        i_q <= i_inc_d;
                    end
                    if (ph_q == PH_CAP) begin
                        si_q    <= s_rddata;
                        ph_q    <= 2'd0;
                        state_q <= ST_PRGA_RJ;
                    end else begin
                        ph_q <= ph_q + 2'd1;
                    end
                end
                ST_PRGA_RJ: begin
                    if (ph_q == 2'd0) begin
                        j_q <= j_prga_d;
                    end
                    if (ph_q == PH_CAP) begin
                        sj_q    <= s_rddata;
                        ph_q    <= 2'd0;
                        state_q <= ST_PRGA_SW;
                    end else begin
                        ph_q <= ph_q + 2'd1;
                    end
                end
                ST_PRGA_SW: begin
                    if (ph_q == 2'd0) begin
                        ph_q <= 2'd1;
                    end else begin
                        ph_q      <= 2'd0;
                        pt_addr_q <= k_q;
                        state_q   <= ST_PRGA_RK;
                    end
                end
                ST_PRGA_RK: begin
                    if (ph_q == PH_CAP) begin
                        ct_addr_q   <= k_q;
                        ct_wrdata_q <= s_rddata ^ pt_rddata;
                        ct_wren_q   <= 1'b1;
                        ph_q        <= 2'd0;
                        state_q     <= ST_PRGA_WC;
                    end else begin
                        ph_q <= ph_q + 2'd1;
                    end
                end
                ST_PRGA_WC: begin
                    ct_wren_q <= 1'b0;
                    if (k_q == len_q) begin
                        rdy_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        k_q     <= k_q + 8'd1;
                        state_q <= ST_PRGA_RI;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: software RC4 model feeds a write scoreboard; pt/ct memories modelled here.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst_n, en, rdy, ct_wren;
    logic [23:0] key;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] kv [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    string ptxt = "Plaintext";

    always #5 clk = ~clk;

    always @(posedge clk) pt_rddata <= pt_mem[pt_addr];
    always @(posedge clk) if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;

    arc4_encrypt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    task automatic build_expected(input logic [23:0] k);
        logic [7:0]  s [256];
        logic [7:0]  i, j, t, len, kb;
        logic [23:0] kk;
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            kk = k >> (8 * (2 - (a % 3)));
            kb = kk[7:0];
            j = j + s[a] + kb;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        len = pt_mem[0];
        exp_q.push_back({8'h00, len});
        i = 8'd0;
        j = 8'd0;
        for (int n = 1; n <= int'(len); n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_q.push_back({8'(n), s[t] ^ pt_mem[n]});
        end
    endtask

    task automatic load_plaintext();
        pt_mem[0] = 8'(ptxt.len());
        for (int n = 0; n < ptxt.len(); n++) pt_mem[n+1] = ptxt[n];
    endtask

    // One encryption with the scoreboard checking every ct write; optional stray en and mid-run reset.
    task automatic do_run(input string name, input logic [23:0] k, input int glitch_at,
                          input int rst_at, input int rst_writes);
        int         cyc, nwr, n_exp;
        logic [7:0] len;
        wr_t        w;
        exp_q.delete();
        build_expected(k);
        n_exp = exp_q.size();
        len   = pt_mem[0];
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        key = ~k;
        cyc = 0;
        nwr = 0;
        while (!rdy && cyc < 6000) begin
            en = (cyc == glitch_at);
            if (ct_wren) begin
                nwr++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s extra_write: got addr=%02h data=%02h, required no write", name, ct_addr, ct_wrdata);
                end else begin
                    w = exp_q.pop_front();
                    if ({ct_addr, ct_wrdata} !== w)
                        $display("FAIL %s ct_write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                                 name, ct_addr, ct_wrdata, w.addr, w.data);
                    else n_pass++;
                end
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                n_total++;
                if (rdy !== 1'b1 || ct_wren !== 1'b0)
                    $display("FAIL %s async_reset: got rdy=%b ct_wren=%b, required rdy=1 ct_wren=0", name, rdy, ct_wren);
                else n_pass++;
                n_total++;
                if (nwr !== rst_writes)
                    $display("FAIL %s writes_before_reset: got %0d, required %0d", name, nwr, rst_writes);
                else n_pass++;
                @(negedge clk);
                rst_n = 1'b1;
                en    = 1'b0;
                exp_q.delete();
                return;
            end
            cyc++;
            @(negedge clk);
        end
        en = 1'b0;
        n_total++;
        if (cyc !== 1795 + 9 * int'(len))
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, cyc, 1795 + 9 * int'(len));
        else n_pass++;
        n_total++;
        if (nwr !== n_exp)
            $display("FAIL %s write_count: got %0d, required %0d", name, nwr, n_exp);
        else n_pass++;
        n_total++;
        if (ct_wren !== 1'b0 || rdy !== 1'b1)
            $display("FAIL %s done_outputs: got rdy=%b ct_wren=%b, required rdy=1 ct_wren=0", name, rdy, ct_wren);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        key   = 24'h0;
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
        #12;
        n_total++;
        if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b, required 1", rdy); else n_pass++;
        n_total++;
        if (ct_wren !== 1'b0) $display("FAIL reset_ct_wren: got %b, required 0", ct_wren); else n_pass++;
        n_total++;
        if (ct_addr !== 8'h00) $display("FAIL reset_ct_addr: got %02h, required 00", ct_addr); else n_pass++;
        n_total++;
        if (ct_wrdata !== 8'h00) $display("FAIL reset_ct_wrdata: got %02h, required 00", ct_wrdata); else n_pass++;
        n_total++;
        if (pt_addr !== 8'h00) $display("FAIL reset_pt_addr: got %02h, required 00", pt_addr); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known_vector();
        load_plaintext();
        do_run("known_vector", 24'h4B6579, -1, -1, 0);
        for (int n = 0; n < 10; n++) begin
            n_total++;
            if (ct_mem[n] !== kv[n])
                $display("FAIL known_vector_ct[%0d]: got %02h, required %02h", n, ct_mem[n], kv[n]);
            else n_pass++;
        end
    endtask

    task automatic test_round_trip();
        for (int n = 0; n < 10; n++) pt_mem[n] = ct_mem[n];
        do_run("round_trip", 24'h4B6579, -1, -1, 0);
        n_total++;
        if (ct_mem[0] !== 8'h09) $display("FAIL round_trip_len: got %02h, required 09", ct_mem[0]); else n_pass++;
        for (int n = 0; n < ptxt.len(); n++) begin
            n_total++;
            if (ct_mem[n+1] !== ptxt[n])
                $display("FAIL round_trip_pt[%0d]: got %02h, required %02h", n, ct_mem[n+1], ptxt[n]);
            else n_pass++;
        end
    endtask

    task automatic test_len0();
        pt_mem[0] = 8'h00;
        pt_mem[1] = 8'hA5;
        do_run("len0", 24'hC0FFEE, -1, -1, 0);
    endtask

    task automatic test_len255();
        pt_mem[0] = 8'hFF;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
        do_run("len255", 24'h000001, -1, -1, 0);
    endtask

    task automatic test_en_ignored_then_reset();
        load_plaintext();
        // Reset lands on the ct[3] write cycle: ct[0..3] already presented.
        do_run("stray_en_reset", 24'h4B6579, 500, 1795 + 9 * 3 - 1, 4);
        do_run("after_reset", 24'h4B6579, -1, -1, 0);
        for (int n = 0; n < 10; n++) begin
            n_total++;
            if (ct_mem[n] !== kv[n])
                $display("FAIL after_reset_ct[%0d]: got %02h, required %02h", n, ct_mem[n], kv[n]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        pt_mem[0] = 8'd20;
        for (int n = 1; n <= 20; n++) pt_mem[n] = 8'($urandom_range(0, 255));
        do_run("b2b_key0", 24'h000000, -1, -1, 0);
        do_run("b2b_key1", 24'h000001, -1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_round_trip();
        test_len0();
        test_len255();
        test_en_ignored_then_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
